// File: rtl/ir_nec_rx.sv
// NEC infrared remote receiver.
// The rx line is synchronised and glitch-filtered. Each filtered level is timed in
// 10 us ticks. A pulse-width state machine collects the payload LSB-first and
// reports a new code, a repeat press or a frame error with single-cycle pulses.
module ir_nec_rx #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned CODEBITS    = 32,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned CHECK_INV   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [CODEBITS-1:0] code,
    output logic                new_code,
    output logic                repeat_press,
    output logic                frame_err,
    output logic                busy
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 100000;
    localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam bit          INV_ON   = (CHECK_INV != 0) && (CODEBITS == 32);

    localparam logic [10:0] PCNT_MAX   = 11'h7FF;
    localparam logic [10:0] LEAD_L_MIN = 11'd800;
    localparam logic [10:0] LEAD_L_MAX = 11'd1000;
    localparam logic [10:0] LEAD_H_MIN = 11'd400;
    localparam logic [10:0] LEAD_H_MAX = 11'd500;
    localparam logic [10:0] REP_H_MIN  = 11'd180;
    localparam logic [10:0] REP_H_MAX  = 11'd270;
    localparam logic [10:0] MARK_MIN   = 11'd40;
    localparam logic [10:0] MARK_MAX   = 11'd80;
    localparam logic [10:0] SP0_MIN    = 11'd40;
    localparam logic [10:0] SP0_MAX    = 11'd80;
    localparam logic [10:0] SP1_MIN    = 11'd140;
    localparam logic [10:0] SP1_MAX    = 11'd200;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LOW,
        LEAD_HIGH,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic                  tick;
    logic [1:0]            sync_q, sync_d;
    logic                  filt_q, filt_d;
    logic [3:0]            filt_cnt_q, filt_cnt_d;
    logic                  filt_prev_q, filt_prev_d;
    logic                  rise, fall;
    logic [10:0]           pcnt_q, pcnt_d;
    logic [5:0]            bit_idx_q, bit_idx_d;
    logic [CODEBITS-1:0]   buf_q, buf_d;
    logic                  rep_q, rep_d;
    logic [CODEBITS-1:0]   code_q, code_d;
    logic                  have_code_q, have_code_d;
    logic                  new_code_q, new_code_d;
    logic                  repeat_q, repeat_d;
    logic                  err_q, err_d;
    logic                  inv_ok;
    logic                  abort;
    logic                  bit_val;

    function automatic logic in_win(input logic [10:0] v, input logic [10:0] lo,
                                    input logic [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // 10 us tick generator, synchroniser, level filter and pulse-width counter.
    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        sync_d     = {sync_q[0], rx};

        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (sync_q[1] != filt_q) begin
            if (filt_cnt_q == 4'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end

        filt_prev_d = filt_q;
        rise        = filt_q & ~filt_prev_q;
        fall        = ~filt_q & filt_prev_q;

        if (rise || fall) begin
            pcnt_d = '0;
        end else if (tick && (pcnt_q != PCNT_MAX)) begin
            pcnt_d = pcnt_q + 11'd1;
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    if (INV_ON) begin : g_inv
        // Address and command bytes must each be followed by their complement.
        always_comb inv_ok = (buf_q[15:8] == ~buf_q[7:0]) && (buf_q[31:24] == ~buf_q[23:16]);
    end else begin : g_no_inv
        // Integrity check disabled: every completed data frame is accepted.
        always_comb inv_ok = 1'b1;
    end

    // Frame decoder: next state, payload collection and result pulses.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        buf_d       = buf_q;
        rep_d       = rep_q;
        code_d      = code_q;
        have_code_d = have_code_q;
        new_code_d  = 1'b0;
        repeat_d    = 1'b0;
        err_d       = 1'b0;
        abort       = 1'b0;
        bit_val     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d   = LEAD_LOW;
                    buf_d     = '0;
                    rep_d     = 1'b0;
                    bit_idx_d = '0;
                end
            end
            LEAD_LOW: begin
                if (rise) begin
                    if (in_win(pcnt_q, LEAD_L_MIN, LEAD_L_MAX)) state_d = LEAD_HIGH;
                    else abort = 1'b1;
                end
            end
            LEAD_HIGH: begin
                if (fall) begin
                    if (in_win(pcnt_q, LEAD_H_MIN, LEAD_H_MAX)) begin
                        state_d   = BIT_LOW;
                        bit_idx_d = '0;
                    end else if (in_win(pcnt_q, REP_H_MIN, REP_H_MAX)) begin
                        state_d = STOP_LOW;
                        rep_d   = 1'b1;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            BIT_LOW: begin
                if (rise) begin
                    if (in_win(pcnt_q, MARK_MIN, MARK_MAX)) state_d = BIT_HIGH;
                    else abort = 1'b1;
                end
            end
            BIT_HIGH: begin
                if (fall) begin
                    if (in_win(pcnt_q, SP0_MIN, SP0_MAX) || in_win(pcnt_q, SP1_MIN, SP1_MAX)) begin
                        bit_val = in_win(pcnt_q, SP1_MIN, SP1_MAX);
                        for (int unsigned i = 0; i < CODEBITS; i++) begin
                            if (bit_idx_q == 6'(i)) buf_d[i] = bit_val;
                        end
                        if (bit_idx_q == 6'(CODEBITS - 1)) begin
                            state_d = STOP_LOW;
                        end else begin
                            state_d   = BIT_LOW;
                            bit_idx_d = bit_idx_q + 6'd1;
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            STOP_LOW: begin
                if (rise) begin
                    if (!in_win(pcnt_q, MARK_MIN, MARK_MAX)) begin
                        abort = 1'b1;
                    end else if (rep_q) begin
                        if (have_code_q) begin
                            repeat_d = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            abort = 1'b1;
                        end
                    end else if (!inv_ok) begin
                        abort = 1'b1;
                    end else begin
                        code_d      = buf_q;
                        new_code_d  = 1'b1;
                        have_code_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && (pcnt_q == PCNT_MAX)) abort = 1'b1;

        if (abort) begin
            state_d     = IDLE;
            err_d       = 1'b1;
            new_code_d  = 1'b0;
            repeat_d    = 1'b0;
            code_d      = code_q;
            have_code_d = have_code_q;
        end
    end

    // All state registers; reset returns the line path to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            sync_q      <= '1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            filt_prev_q <= 1'b1;
            pcnt_q      <= '0;
            bit_idx_q   <= '0;
            buf_q       <= '0;
            rep_q       <= 1'b0;
            code_q      <= '0;
            have_code_q <= 1'b0;
            new_code_q  <= 1'b0;
            repeat_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            sync_q      <= sync_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            filt_prev_q <= filt_prev_d;
            pcnt_q      <= pcnt_d;
            bit_idx_q   <= bit_idx_d;
            buf_q       <= buf_d;
            rep_q       <= rep_d;
            code_q      <= code_d;
            have_code_q <= have_code_d;
            new_code_q  <= new_code_d;
            repeat_q    <= repeat_d;
            err_q       <= err_d;
        end
    end

    assign code         = code_q;
    assign new_code     = new_code_q;
    assign repeat_press = repeat_q;
    assign frame_err    = err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ir_nec_rx.sv
// Bench for ir_nec_rx: two receivers (inverse check on / off) share one rx line.
// Frames are built from randomised NEC timings, and a frame-level model predicts each outcome.
`timescale 1ns/1ps
module tb_ir_nec_rx;
    localparam int unsigned CLK_HZ     = 200000;
    localparam int unsigned US_PER_CYC = 5;
    localparam int K_DATA = 0;
    localparam int K_REP  = 1;
    localparam int K_BAD  = 2;
    localparam int K_RST  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [31:0] code_o [2];
    logic        new_o  [2];
    logic        rep_o  [2];
    logic        err_o  [2];
    logic        busy_o [2];

    ir_nec_rx #(.CLK_FREQ_HZ(CLK_HZ), .CODEBITS(32), .FILTER_LEN(4), .CHECK_INV(1)) u_dut_inv (
        .clk(clk), .rst(rst), .rx(rx), .code(code_o[0]), .new_code(new_o[0]),
        .repeat_press(rep_o[0]), .frame_err(err_o[0]), .busy(busy_o[0]));

    ir_nec_rx #(.CLK_FREQ_HZ(CLK_HZ), .CODEBITS(32), .FILTER_LEN(4), .CHECK_INV(0)) u_dut_noinv (
        .clk(clk), .rst(rst), .rx(rx), .code(code_o[1]), .new_code(new_o[1]),
        .repeat_press(rep_o[1]), .frame_err(err_o[1]), .busy(busy_o[1]));

    always #2500 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_new [2] = '{0, 0};
    int   n_rep [2] = '{0, 0};
    int   n_err [2] = '{0, 0};
    int   n_viol = 0;
    int   pulse_cyc [2] = '{0, 0};
    logic prev_any [2] = '{1'b0, 1'b0};
    int   rise_cyc = 0;

    int          s_new [2], s_rep [2], s_err [2];
    int          e_new [2], e_rep [2], e_err [2];
    logic [31:0] m_code [2];
    logic        m_have [2];

    // Pulse monitor: counts result pulses and flags overlapping or back-to-back pulses.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (int'(new_o[i]) + int'(rep_o[i]) + int'(err_o[i]) > 1) n_viol++;
            if ((new_o[i] | rep_o[i] | err_o[i]) && prev_any[i]) n_viol++;
            if (new_o[i]) n_new[i]++;
            if (rep_o[i]) n_rep[i]++;
            if (err_o[i]) n_err[i]++;
            if (new_o[i] | rep_o[i] | err_o[i]) pulse_cyc[i] = cyc;
            prev_any[i] = new_o[i] | rep_o[i] | err_o[i];
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned jit(input int unsigned lo, input int unsigned hi);
        return $urandom_range(hi, lo);
    endfunction

    task automatic seg(input logic lvl, input int unsigned us);
        if (lvl && !rx) rise_cyc = cyc;
        rx = lvl;
        repeat (us / US_PER_CYC) @(negedge clk);
    endtask

    // gl: 0 clean, 1 two-cycle high glitch in the mark, 2 three-cycle low glitch in the space
    task automatic send_bit(input logic b, input int gl);
        int unsigned mk;
        int unsigned sp;
        mk = jit(480, 650);
        sp = b ? jit(1550, 1800) : jit(480, 650);
        if (gl == 1) begin
            seg(1'b0, 200); seg(1'b1, 10); seg(1'b0, mk - 210);
        end else begin
            seg(1'b0, mk);
        end
        if (gl == 2) begin
            seg(1'b1, 200); seg(1'b0, 15); seg(1'b1, sp - 215);
        end else begin
            seg(1'b1, sp);
        end
    endtask

    task automatic send_lead(input logic rep);
        seg(1'b0, jit(8500, 9500));
        seg(1'b1, rep ? jit(2100, 2400) : jit(4300, 4700));
    endtask

    // Data frame; ends low at the stop mark so the closing rise comes from frame_end.
    task automatic send_data(input logic [31:0] p, input logic glitchy);
        send_lead(1'b0);
        for (int i = 0; i < 32; i++) begin
            send_bit(p[i], glitchy ? ((i == 5) ? 1 : (i == 7) ? 2 : 0) : 0);
        end
        seg(1'b0, jit(480, 650));
    endtask

    task automatic send_repeat();
        send_lead(1'b1);
        seg(1'b0, jit(480, 650));
    endtask

    task automatic send_bad(input int kind);
        case (kind)
            0: seg(1'b0, 6000);
            1: begin seg(1'b0, jit(8500, 9500)); seg(1'b1, 3000); seg(1'b0, 560); end
            2: begin send_lead(1'b0); send_bit(1'($urandom), 0); seg(1'b0, 250); end
            3: begin
                send_lead(1'b0); send_bit(1'($urandom), 0);
                seg(1'b0, jit(480, 650)); seg(1'b1, 1100); seg(1'b0, 560);
            end
            default: seg(1'b0, 22000);
        endcase
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            s_new[i] = n_new[i]; s_rep[i] = n_rep[i]; s_err[i] = n_err[i];
        end
    endtask

    // Frame-level reference: outcome of one frame for each receiver.
    task automatic model(input int kind, input logic [31:0] p);
        logic ok;
        for (int i = 0; i < 2; i++) begin
            e_new[i] = 0; e_rep[i] = 0; e_err[i] = 0;
            case (kind)
                K_DATA: begin
                    ok = (i == 1) || ((p[15:8] == ~p[7:0]) && (p[31:24] == ~p[23:16]));
                    if (ok) begin
                        e_new[i] = 1; m_code[i] = p; m_have[i] = 1'b1;
                    end else begin
                        e_err[i] = 1;
                    end
                end
                K_REP: begin
                    if (m_have[i]) e_rep[i] = 1;
                    else e_err[i] = 1;
                end
                K_BAD: e_err[i] = 1;
                default: begin m_code[i] = '0; m_have[i] = 1'b0; end
            endcase
        end
    endtask

    task automatic frame_end(input string tag, input logic lat);
        seg(1'b1, 500);
        for (int i = 0; i < 2; i++) begin
            chk_eq($sformatf("%s_new%0d", tag, i), n_new[i] - s_new[i], e_new[i]);
            chk_eq($sformatf("%s_rep%0d", tag, i), n_rep[i] - s_rep[i], e_rep[i]);
            chk_eq($sformatf("%s_err%0d", tag, i), n_err[i] - s_err[i], e_err[i]);
            chk_eq($sformatf("%s_code%0d", tag, i), code_o[i], m_code[i]);
            chk_eq($sformatf("%s_busy%0d", tag, i), busy_o[i], 0);
            if (lat) chk_eq($sformatf("%s_lat%0d", tag, i), pulse_cyc[i] - rise_cyc, 7);
        end
    endtask

    initial begin
        logic [31:0] p;
        logic [7:0]  a;
        logic [7:0]  c;
        int          off;
        int          kind;
        for (int i = 0; i < 2; i++) begin
            m_code[i] = '0; m_have[i] = 1'b0;
        end

        repeat (10) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk_eq($sformatf("rst_code%0d", i), code_o[i], 0);
            chk_eq($sformatf("rst_pulses%0d", i), {new_o[i], rep_o[i], err_o[i]}, 0);
            chk_eq($sformatf("rst_busy%0d", i), busy_o[i], 0);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);

        snap(); model(K_REP, '0); send_repeat(); frame_end("rep_cold", 1'b1);

        seg(1'b0, 15); seg(1'b1, 300);
        for (int i = 0; i < 2; i++) chk_eq($sformatf("idle_glitch_busy%0d", i), busy_o[i], 0);

        p = 32'hBA45FF00;
        snap(); model(K_DATA, p); send_data(p, 1'b1); frame_end("data_glitch", 1'b1);

        snap(); model(K_REP, '0); send_repeat(); frame_end("rep_warm", 1'b1);

        p = 32'hBA45FE00;
        snap(); model(K_DATA, p); send_data(p, 1'b0); frame_end("inv_bad", 1'b1);

        off = int'($urandom_range(4, 0));
        for (int k = 0; k < 5; k++) begin
            kind = (k + off) % 5;
            snap(); model(K_BAD, '0); send_bad(kind);
            frame_end($sformatf("bad%0d", kind), 1'b0);
        end

        snap();
        send_lead(1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
        seg(1'b0, jit(480, 650));
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk_eq("mid_frame_busy", busy_o[0], 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk_eq($sformatf("in_rst_code%0d", i), code_o[i], 0);
            chk_eq($sformatf("in_rst_busy%0d", i), busy_o[i], 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model(K_RST, '0);
        frame_end("rst_mid", 1'b0);

        snap(); model(K_REP, '0); send_repeat(); frame_end("rep_after_rst", 1'b1);

        a = 8'($urandom);
        c = 8'($urandom);
        p = {~c, c, ~a, a};
        snap(); model(K_DATA, p); send_data(p, 1'b0); frame_end("data_rand", 1'b1);

        chk_eq("pulse_excl", n_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
